sound_arbiter: RTL

Shares the single Sound engine (buzzer output) between several note sources: free-play keys, auto-play song reader and play-mode hit feedback. Requesters raise a level req with a latched note. The arbiter grants one requester round-robin, loads the note into Sound, holds enable until Sound reports over, then returns a done pulse and inserts a silent gap. It sits between the mode blocks and the one Sound instance in the top level, replacing the ad-hoc en_sd | ~over gating.

---
 rtl/sound_arbiter_pkg.sv | 30 +++
 rtl/sound_arbiter_if.sv | 35 +++
 rtl/sound_arbiter_rr_picker.sv | 33 +++
 rtl/sound_arbiter.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/sound_arbiter_pkg.sv
// Shared constants, state encoding and sizing helper for the sound arbiter.
package sound_arbiter_pkg;

  // Note field widths used across the sound path.
  localparam int OCTAVE_BITS = 2;
  localparam int NOTE_BITS   = 3;
  localparam int LENGTH_BITS = 3;

  // Requester slots feeding the single Sound engine.
  localparam int REQ_FREE  = 0;
  localparam int REQ_AUTO  = 1;
  localparam int REQ_PLAY  = 2;
  localparam int N_REQ_DEF = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_PLAY,
    ST_FINISH,
    ST_GAP
  } arb_state_e;

  // Width of a counter that must reach the larger of the start timeout and gap.
  function automatic int cnt_width(input int start_to, input int gap);
    int m;
    m = (start_to > gap) ? start_to : gap;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/sound_arbiter_if.sv
// Bundle of requester-side and Sound-side signals around the arbiter.
interface sound_arbiter_if
  import sound_arbiter_pkg::*;
#(
  parameter int N_REQ  = N_REQ_DEF,
  parameter int OCT_W  = OCTAVE_BITS,
  parameter int NOTE_W = NOTE_BITS,
  parameter int LEN_W  = LENGTH_BITS
);
  logic [N_REQ-1:0]        req;
  logic [N_REQ*OCT_W-1:0]  octave_in;
  logic [N_REQ*NOTE_W-1:0] note_in;
  logic [N_REQ*LEN_W-1:0]  length_in;
  logic                    sd_over;
  logic [N_REQ-1:0]        grant;
  logic [N_REQ-1:0]        done;
  logic                    abort;
  logic                    sd_en;
  logic [OCT_W-1:0]        sd_octave;
  logic [NOTE_W-1:0]       sd_note;
  logic [LEN_W-1:0]        sd_length;
  logic                    busy;

  // System side: mode blocks raise requests, Sound reports over.
  modport master (
    output req, octave_in, note_in, length_in, sd_over,
    input  grant, done, abort, sd_en, sd_octave, sd_note, sd_length, busy
  );

  // Arbiter side.
  modport slave (
    input  req, octave_in, note_in, length_in, sd_over,
    output grant, done, abort, sd_en, sd_octave, sd_note, sd_length, busy
  );
endinterface

// File: rtl/sound_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request at or above the pointer, with wrap.
module sound_arbiter_rr_picker #(
  parameter int N_REQ = 3,
  parameter int PTR_W = 2
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [PTR_W-1:0] ptr_i,
  output logic [N_REQ-1:0] gnt_o,
  output logic [PTR_W-1:0] idx_o,
  output logic             vld_o
);

  // Scan from the pointer upward and keep the first hit.
  always_comb begin
    int  j;
    logic found;
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    j     = 0;
    for (int k = 0; k < N_REQ; k++) begin
      j = int'(ptr_i) + k;
      if (j >= N_REQ) j = j - N_REQ;
      if (!found && req_i[j]) begin
        found    = 1'b1;
        gnt_o[j] = 1'b1;
        idx_o    = PTR_W'(j);
      end
    end
    vld_o = found;
  end

endmodule

// File: rtl/sound_arbiter.sv
// Shares one Sound engine among note requesters: round-robin grant, hold
// enable until Sound finishes (or times out / owner cancels), pulse done,
// then enforce a silent gap before the next note.
module sound_arbiter
  import sound_arbiter_pkg::*;
#(
  parameter int N_REQ    = N_REQ_DEF,
  parameter int OCT_W    = OCTAVE_BITS,
  parameter int NOTE_W   = NOTE_BITS,
  parameter int LEN_W    = LENGTH_BITS,
  parameter int START_TO = 16,
  parameter int GAP      = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  sound_arbiter_if.slave  bus
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CNT_W = cnt_width(START_TO, GAP);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;
  localparam logic [CNT_W-1:0] START_LAST = CNT_W'(START_TO - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP - 1);
  localparam logic [PTR_W-1:0] PTR_LAST   = PTR_W'(N_REQ - 1);

  arb_state_e        state_q, state_d;
  logic [N_REQ-1:0]  grant_q, grant_d;
  logic [N_REQ-1:0]  done_q, done_d;
  logic              abort_q, abort_d;
  logic              sd_en_q, sd_en_d;
  logic [OCT_W-1:0]  oct_q, oct_d;
  logic [NOTE_W-1:0] note_q, note_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [PTR_W-1:0]  rr_q, rr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [N_REQ-1:0]  pick_gnt;
  logic [PTR_W-1:0]  pick_idx;
  logic              pick_vld;
  logic              owner_req;
  logic              fin;
  logic              fin_abort;

  // Counters hold at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

  sound_arbiter_rr_picker #(
    .N_REQ (N_REQ),
    .PTR_W (PTR_W)
  ) u_picker (
    .req_i (bus.req),
    .ptr_i (rr_q),
    .gnt_o (pick_gnt),
    .idx_o (pick_idx),
    .vld_o (pick_vld)
  );

  assign owner_req = |(bus.req & grant_q);

  // Next-state and registered-output logic; a finish request from any
  // service state funnels into one common exit path.
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    done_d    = '0;
    abort_d   = 1'b0;
    sd_en_d   = sd_en_q;
    oct_d     = oct_q;
    note_d    = note_q;
    len_d     = len_q;
    rr_d      = rr_q;
    cnt_d     = cnt_q;
    fin       = 1'b0;
    fin_abort = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (pick_vld) begin
          grant_d = pick_gnt;
          oct_d   = bus.octave_in[int'(pick_idx)*OCT_W +: OCT_W];
          note_d  = bus.note_in[int'(pick_idx)*NOTE_W +: NOTE_W];
          len_d   = bus.length_in[int'(pick_idx)*LEN_W +: LEN_W];
          sd_en_d = 1'b1;
          rr_d    = (pick_idx == PTR_LAST) ? '0 : pick_idx + 1'b1;
          cnt_d   = '0;
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (!owner_req) begin
          fin       = 1'b1;
          fin_abort = 1'b1;
        end else if (!bus.sd_over) begin
          cnt_d   = '0;
          state_d = ST_PLAY;
        end else if (cnt_q == START_LAST) begin
          fin       = 1'b1;
          fin_abort = 1'b1;
        end else begin
          cnt_d = sat_inc(cnt_q);
        end
      end
      ST_PLAY: begin
        if (!owner_req) begin
          fin       = 1'b1;
          fin_abort = 1'b1;
        end else if (bus.sd_over) begin
          fin = 1'b1;
        end
      end
      ST_FINISH: begin
        cnt_d   = '0;
        state_d = ST_GAP;
      end
      ST_GAP: begin
        sd_en_d = 1'b0;
        if (cnt_q == GAP_LAST) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = sat_inc(cnt_q);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (fin) begin
      done_d  = grant_q;
      abort_d = fin_abort;
      grant_d = '0;
      sd_en_d = 1'b0;
      state_d = ST_FINISH;
    end
  end

  // State and output registers; reset clears everything including the note latch.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      done_q  <= '0;
      abort_q <= 1'b0;
      sd_en_q <= 1'b0;
      oct_q   <= '0;
      note_q  <= '0;
      len_q   <= '0;
      rr_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      done_q  <= done_d;
      abort_q <= abort_d;
      sd_en_q <= sd_en_d;
      oct_q   <= oct_d;
      note_q  <= note_d;
      len_q   <= len_d;
      rr_q    <= rr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.grant     = grant_q;
  assign bus.done      = done_q;
  assign bus.abort     = abort_q;
  assign bus.sd_en     = sd_en_q;
  assign bus.sd_octave = oct_q;
  assign bus.sd_note   = note_q;
  assign bus.sd_length = len_q;
  assign bus.busy      = (state_q != ST_IDLE);

endmodule
